// File: rtl/risc_control_fsm.sv
// Multi-cycle control FSM for the 8-bit RISC core: fetch/decode/exec/mem/wb sequencing
// with a memory-ready timeout. Optional interrupt support is enabled by RISC_CTRL_IRQ_EN.
module risc_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
`ifdef RISC_CTRL_IRQ_EN
    input  logic       irq,
    output logic       irq_ack,
`endif
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_ld,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       wb_sel,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
`ifdef RISC_CTRL_IRQ_EN
        , S_IRQ
`endif
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_OR = 4'h4, OP_LD = 4'h5, OP_ST = 4'h6, OP_BEQZ = 4'h7,
                           OP_JMP = 4'h8, OP_EI = 4'hE, OP_HLT = 4'hF;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [3:0] opcode_reg, opcode_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       go_fetch;
`ifdef RISC_CTRL_IRQ_EN
    logic       ie_reg, ie_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_FETCH;
            opcode_reg <= OP_NOP;
            cnt_reg    <= 8'd0;
`ifdef RISC_CTRL_IRQ_EN
            ie_reg     <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            cnt_reg    <= cnt_next;
`ifdef RISC_CTRL_IRQ_EN
            ie_reg     <= ie_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        cnt_next    = cnt_reg;
        go_fetch    = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        ir_ld       = 1'b0;
        addr_sel    = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        alu_op      = 2'd0;
        halted      = 1'b0;
        fault       = 1'b0;
        illegal     = 1'b0;
`ifdef RISC_CTRL_IRQ_EN
        ie_next     = ie_reg;
        irq_ack     = 1'b0;
`endif
        case (state_reg)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_ld      = 1'b1;
                    state_next = S_DECODE;
                end else if (cnt_reg == TIMEOUT) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DECODE: begin
                opcode_next = opcode;
                pc_we       = 1'b1;
                state_next  = S_EXEC;
            end
            S_EXEC: begin
                case (opcode_reg)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        alu_op   = opcode_reg[1:0] - 2'd1;
                        reg_we   = 1'b1;
                        go_fetch = 1'b1;
                    end
                    OP_LD, OP_ST: state_next = S_MEM;
                    OP_BEQZ: begin
                        pc_we    = zero;
                        pc_src   = zero ? 2'd1 : 2'd0;
                        go_fetch = 1'b1;
                    end
                    OP_JMP: begin
                        pc_we    = 1'b1;
                        pc_src   = 2'd2;
                        go_fetch = 1'b1;
                    end
                    OP_HLT: state_next = S_HALT;
                    OP_NOP: go_fetch = 1'b1;
`ifdef RISC_CTRL_IRQ_EN
                    OP_EI: begin
                        ie_next  = 1'b1;
                        go_fetch = 1'b1;
                    end
`endif
                    default: begin
                        illegal  = 1'b1;
                        go_fetch = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                mem_rd   = (opcode_reg == OP_LD);
                mem_wr   = (opcode_reg == OP_ST);
                if (mem_ready) begin
                    if (opcode_reg == OP_LD)
                        state_next = S_WB;
                    else
                        go_fetch = 1'b1;
                end else if (cnt_reg == TIMEOUT) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                wb_sel   = 1'b1;
                go_fetch = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
`ifdef RISC_CTRL_IRQ_EN
            S_IRQ: begin
                pc_we      = 1'b1;
                pc_src     = 2'd3;
                irq_ack    = 1'b1;
                ie_next    = 1'b0;
                state_next = S_FETCH;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        // Instruction boundary: an enabled pending interrupt diverts to IRQ.
        if (go_fetch) begin
            state_next = S_FETCH;
`ifdef RISC_CTRL_IRQ_EN
            if (irq && ie_reg)
                state_next = S_IRQ;
`endif
        end

        if (state_next != state_reg)
            cnt_next = 8'd0;
    end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Self-checking bench for risc_control_fsm: per-instruction expected output traces
// built from the opcode rules, random opcodes/wait states, directed corner cases.
module tb_risc_control_fsm;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [3:0] opcode;
    logic       pc_we, ir_ld, addr_sel, mem_rd, mem_wr, reg_we, wb_sel;
    logic       halted, fault, illegal, ack_w;
    logic [1:0] pc_src, alu_op;
    logic       irq_last = 1'b0;
    bit         irq_hold = 1'b0;
    bit         ie_m = 1'b0;
    int         vectors = 0, miscompares = 0;

    // Expected-vector bit fields
    localparam logic [14:0] PCWE = 15'h4000, IRLD = 15'h0800, ASEL = 15'h0400,
                            MRD = 15'h0200, MWR = 15'h0100, RWE = 15'h0080,
                            WBS = 15'h0040, HLTD = 15'h0008, FLT = 15'h0004,
                            ILL = 15'h0002, ACK = 15'h0001;

    always #5 clk = ~clk;

`ifdef RISC_CTRL_IRQ_EN
    logic irq, irq_ack;
    assign ack_w = irq_ack;
`else
    assign ack_w = 1'b0;
`endif

    risc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
`ifdef RISC_CTRL_IRQ_EN
        .irq(irq), .irq_ack(irq_ack),
`endif
        .pc_we(pc_we), .pc_src(pc_src), .ir_ld(ir_ld), .addr_sel(addr_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .halted(halted), .fault(fault), .illegal(illegal)
    );

    logic [14:0] obs;
    assign obs = {pc_we, pc_src, ir_ld, addr_sel, mem_rd, mem_wr, reg_we, wb_sel,
                  alu_op, halted, fault, illegal, ack_w};

    function automatic logic [14:0] pcs(input int v);
        return 15'(v) << 12;
    endfunction
    function automatic logic [14:0] alu(input int v);
        return 15'(v) << 4;
    endfunction
    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive inputs, check settled outputs at the falling edge, advance.
    task automatic cyc(input logic rdy, input logic [3:0] op, input logic z,
                       input logic [14:0] exp, input string tag);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
`ifdef RISC_CTRL_IRQ_EN
        irq      = irq_hold ? 1'b1 : rb();
        irq_last = irq;
`endif
        @(negedge clk);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = rb();
        opcode    = rop();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        ie_m = 1'b0;
    endtask

    // mw > TO means memory never answers in MEM (timeout to FAULT)
    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        logic [14:0] base;
        bit          ie_old;
        $display("instr op=%h zero=%0d fetch_wait=%0d mem_wait=%0d", op, z, fw, mw);
        for (int i = 0; i < fw; i++) cyc(1'b0, rop(), rb(), MRD, "fetch_wait");
        cyc(1'b1, rop(), rb(), MRD | IRLD, "fetch");
        cyc(rb(), op, rb(), PCWE, "decode");
        ie_old = ie_m;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4: cyc(rb(), rop(), z, RWE | alu(int'(op) - 1), "exec_alu");
            4'h5, 4'h6: begin
                cyc(rb(), rop(), z, 15'h0, "exec_mem");
                base = ASEL | ((op == 4'h5) ? MRD : MWR);
                if (mw > TO) begin
                    for (int i = 0; i <= TO; i++) cyc(1'b0, rop(), rb(), base, "mem_stuck");
                    for (int i = 0; i < 3; i++) cyc(rb(), rop(), rb(), FLT, "mem_fault");
                    do_reset();
                    return;
                end
                for (int i = 0; i < mw; i++) cyc(1'b0, rop(), rb(), base, "mem_wait");
                cyc(1'b1, rop(), rb(), base, "mem_done");
                if (op == 4'h5) cyc(rb(), rop(), rb(), RWE | WBS, "wb");
            end
            4'h7: cyc(rb(), rop(), z, z ? (PCWE | pcs(1)) : 15'h0, "exec_beqz");
            4'h8: cyc(rb(), rop(), z, PCWE | pcs(2), "exec_jmp");
            4'hF: begin
                cyc(rb(), rop(), z, 15'h0, "exec_hlt");
                for (int i = 0; i < 3; i++) cyc(rb(), rop(), rb(), HLTD, "halt");
                do_reset();
                return;
            end
            4'h0: cyc(rb(), rop(), z, 15'h0, "exec_nop");
`ifdef RISC_CTRL_IRQ_EN
            4'hE: begin
                cyc(rb(), rop(), z, 15'h0, "exec_ei");
                ie_m = 1'b1;
            end
`endif
            default: cyc(rb(), rop(), z, ILL, "exec_illegal");
        endcase
`ifdef RISC_CTRL_IRQ_EN
        if (irq_last && ie_old) begin
            cyc(rb(), rop(), rb(), PCWE | pcs(3) | ACK, "irq");
            ie_m = 1'b0;
        end
`endif
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 4'h0; zero = 1'b0;
`ifdef RISC_CTRL_IRQ_EN
        irq = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD with ready memory, then LD with 3 wait states in MEM
        run_instr(4'h1, 1'b0, 0, 0);
        run_instr(4'h5, 1'b0, 0, 3);
        // Branch not taken / taken
        run_instr(4'h7, 1'b0, 0, 0);
        run_instr(4'h7, 1'b1, 1, 0);
        run_instr(4'h8, 1'b0, TO, 0);
        run_instr(4'h9, 1'b0, 0, 0);
        run_instr(4'h6, 1'b0, 0, TO);

        // Fetch timeout: TO+1 waiting FETCH cycles then sticky FAULT
        for (int i = 0; i <= TO; i++) cyc(1'b0, rop(), rb(), MRD, "to_fetch");
        for (int i = 0; i < 3; i++) cyc(1'b1, rop(), rb(), FLT, "to_fault");
        do_reset();
        run_instr(4'h0, 1'b0, 0, 0);

        // HLT, then reset in the middle of a stalled ST
        run_instr(4'hF, 1'b0, 0, 0);
        cyc(1'b1, rop(), rb(), MRD | IRLD, "st_fetch");
        cyc(rb(), 4'h6, rb(), PCWE, "st_decode");
        cyc(rb(), rop(), rb(), 15'h0, "st_exec");
        cyc(1'b0, rop(), rb(), ASEL | MWR, "st_mem");
        rst = 1'b1;
        cyc(1'b0, rop(), rb(), ASEL | MWR, "st_mem_rst");
        rst  = 1'b0;
        ie_m = 1'b0;
        cyc(1'b0, rop(), rb(), MRD, "after_rst");
        run_instr(4'h2, 1'b0, 0, 0);

`ifdef RISC_CTRL_IRQ_EN
        // EI then two ADDs with irq held: only the first is interrupted
        do_reset();
        run_instr(4'hE, 1'b0, 0, 0);
        irq_hold = 1'b1;
        run_instr(4'h1, 1'b0, 0, 0);
        run_instr(4'h1, 1'b0, 0, 0);
        irq_hold = 1'b0;
`endif

        for (int n = 0; n < 200; n++)
            run_instr(rop(), rb(), $urandom_range(0, TO),
                      ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/risc_control_fsm.md
Name: risc_control_fsm

Overview:
- Multi-cycle control unit for the 8-bit RISC core.
- Sequences the fetch, decode, execute, memory and writeback phases.
- Drives the program counter write enable (pc_we, feeds PC load strobe) and the PC next-address mux select.
- Drives instruction register load, register-file write, ALU op and memory strobes, with a ready handshake to instruction/data memory.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting on mem_ready in FETCH or MEM before entering FAULT; legal range 1-255.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  4  ir[7:4]; sampled by the FSM only in DECODE
- zero  in  1  ALU zero flag, used by BEQZ in EXEC
- mem_ready  in  1  memory handshake; access completes on a cycle with mem_rd|mem_wr=1 and mem_ready=1
- pc_we  out  1  PC load enable, one-cycle pulse
- pc_src  out  2  PC mux select: 0=PC+1, 1=branch target, 2=jump target, 3=IRQ vector
- ir_ld  out  1  instruction register load
- addr_sel  out  1  memory address: 0=PC, 1=operand
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- reg_we  out  1  register file write
- wb_sel  out  1  writeback source: 0=ALU, 1=memory
- alu_op  out  2  0=ADD, 1=SUB, 2=AND, 3=OR
- halted  out  1  high in HALT
- fault  out  1  high in FAULT, sticky until rst
- illegal  out  1  one-cycle pulse in EXEC for an undefined opcode

Behaviour:
- Opcode map:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR
  - 5 LD, 6 ST
  - 7 BEQZ, 8 JMP
  - E EI (only with the optional feature; otherwise undefined)
  - F HLT
  - all other codes undefined: behave as NOP and pulse illegal
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT (plus IRQ with the optional feature).
- Outputs are combinational from state, the latched opcode and the inputs. Every output is 0 unless listed below.
- Reset: any cycle with rst=1 puts state in FETCH at the next edge and clears the latched opcode, the timeout counter, fault and halted. Reset mid-access abandons the access with no further strobes. Reset has priority over every other event.
- FETCH:
  - addr_sel=0, mem_rd=1.
  - If mem_ready=1: ir_ld=1, next state DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Latch opcode.
  - pc_we=1, pc_src=0 (PC increments exactly once per instruction).
  - Next state EXEC.
- EXEC:
  - ALU ops (1-4): alu_op = opcode-1, reg_we=1, wb_sel=0; next FETCH.
  - LD/ST: next MEM.
  - BEQZ: if zero=1 then pc_we=1, pc_src=1; next FETCH either way.
  - JMP: pc_we=1, pc_src=2; next FETCH.
  - HLT: next HALT.
  - NOP and undefined codes: next FETCH.
- MEM:
  - addr_sel=1; mem_rd=1 for LD, mem_wr=1 for ST.
  - On mem_ready=1: LD goes to WB, ST goes to FETCH.
  - Otherwise wait and count.
- WB: reg_we=1, wb_sel=1; next FETCH.
- HALT: all strobes 0, halted=1; left only by rst.
- FAULT: fault=1, all strobes 0; left only by rst.
- Timeout counter:
  - 8 bits; cleared on every state change.
  - Increments on each FETCH or MEM cycle with mem_ready=0.
  - When it equals MEM_TIMEOUT with mem_ready still 0, next state is FAULT.
  - mem_ready=1 on that same cycle completes normally; completion has priority over timeout.
- Latency with a ready memory (mem_ready=1 on first request):
  - NOP/ALU/branch/JMP: 3 cycles
  - ST: 4 cycles
  - LD: 5 cycles
- Exactly one pc_we pulse in DECODE per instruction, plus at most one more in EXEC (taken branch or jump).

Optional Feature:
- Macro: RISC_CTRL_IRQ_EN.
- When defined:
  - Adds input irq (1) and output irq_ack (1), plus an internal interrupt-enable bit ie (reset value 0).
  - When the FSM would go to FETCH from EXEC, MEM (ST) or WB, and irq=1 and ie=1, next state is IRQ instead.
  - IRQ: pc_we=1, pc_src=3, irq_ack=1, ie cleared; next FETCH.
  - Opcode E (EI) sets ie in EXEC and does not pulse illegal.
- When undefined:
  - No irq or irq_ack ports and no IRQ state.
  - pc_src never equals 3.
  - Opcode E is undefined: NOP plus illegal pulse.

Test Plan:
- Reset, then opcode=1 (ADD) with mem_ready tied 1 -> cycle 1 mem_rd=1, ir_ld=1; cycle 2 pc_we=1, pc_src=0; cycle 3 reg_we=1, alu_op=0, wb_sel=0; cycle 4 back in FETCH.
- LD with mem_ready low 3 cycles in MEM, then high -> mem_rd held 4 MEM cycles, then one WB cycle with reg_we=1, wb_sel=1; total 8 cycles.
- BEQZ with zero=0, then BEQZ with zero=1 -> the first gives only the DECODE pc_we; the second also gives pc_we=1, pc_src=1 in EXEC.
- mem_ready stuck 0 in FETCH, MEM_TIMEOUT=4 -> fault=1 after 5 FETCH cycles; strobes stay 0; rst returns to FETCH with fault=0.
- HLT, then rst pulse mid-MEM of a following ST -> halted=1 until rst; rst during MEM drops mem_wr on the next cycle and restarts in FETCH.
- With RISC_CTRL_IRQ_EN: EI, then irq=1 during the next ADD -> after ADD's EXEC, one IRQ cycle with pc_we=1, pc_src=3, irq_ack=1; a second irq is ignored until the next EI.
